// File: rtl/dns_filter_enforcer.sv
// Packet-verdict enforcer: buffers AXI4-Stream beats and forwards or silently
// discards each packet according to the one-bit verdict from the DNS parser.
module dns_filter_enforcer #(
   parameter int C_BUS_DATA_WIDTH = 512,
   parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 8,
   parameter int C_FIFO_DEPTH     = 64,
   parameter int C_VERDICT_DEPTH  = 8,
   parameter bit C_PASS_ON_MATCH  = 1'b1
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [C_BUS_DATA_WIDTH-1:0] IN_PACKET_TDATA,
   input  logic [C_BUS_KEEP_WIDTH-1:0] IN_PACKET_TKEEP,
   input  logic                        IN_PACKET_TVALID,
   input  logic                        IN_PACKET_TLAST,
   output logic                        IN_PACKET_TREADY,
   input  logic                        RULE_TDATA,
   input  logic                        RULE_TVALID,
   output logic [C_BUS_DATA_WIDTH-1:0] OUT_PACKET_TDATA,
   output logic [C_BUS_KEEP_WIDTH-1:0] OUT_PACKET_TKEEP,
   output logic                        OUT_PACKET_TLAST,
   output logic                        OUT_PACKET_TVALID,
   input  logic                        OUT_PACKET_TREADY,
   output logic [31:0]                 PASS_COUNT,
   output logic [31:0]                 DROP_COUNT,
   output logic                        VERDICT_ERROR
);

   localparam int FAW = $clog2(C_FIFO_DEPTH);
   localparam int VAW = $clog2(C_VERDICT_DEPTH);
   localparam int BW  = 1 + C_BUS_KEEP_WIDTH + C_BUS_DATA_WIDTH;
   localparam logic [VAW:0] PKTS_MAX = (VAW + 1)'(C_VERDICT_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   logic [BW-1:0]              pkt_mem_q [C_FIFO_DEPTH];
   logic [FAW:0]               pkt_wr_q, pkt_wr_d, pkt_rd_q, pkt_rd_d;
   logic [C_VERDICT_DEPTH-1:0] v_mem_q, v_mem_d;
   logic [VAW:0]               v_wr_q, v_wr_d, v_rd_q, v_rd_d;
   logic [VAW:0]               pkts_open_q, pkts_open_d;
   logic                       in_sop_q, in_sop_d;
   logic                       rdy_en_q;
   logic                       verr_q, verr_d;
   state_t                     state_q;
   logic [31:0]                pass_cnt_q, drop_cnt_q;

   logic          pkt_full_s, pkt_empty_s, pkt_wr_s, pkt_rd_s;
   logic          v_full_s, v_empty_s, v_wr_s, v_pop_s, v_head_s;
   logic [BW-1:0] head_s;

   // MSB differs with equal low bits means the write pointer has lapped the read pointer
   assign pkt_empty_s = (pkt_wr_q == pkt_rd_q);
   assign pkt_full_s  = (pkt_wr_q[FAW] != pkt_rd_q[FAW]) && (pkt_wr_q[FAW-1:0] == pkt_rd_q[FAW-1:0]);
   assign v_empty_s   = (v_wr_q == v_rd_q);
   assign v_full_s    = (v_wr_q[VAW] != v_rd_q[VAW]) && (v_wr_q[VAW-1:0] == v_rd_q[VAW-1:0]);

   assign head_s   = pkt_mem_q[pkt_rd_q[FAW-1:0]];
   assign v_head_s = v_mem_q[v_rd_q[VAW-1:0]];

   // A new packet may not start once every verdict slot is already spoken for
   assign IN_PACKET_TREADY  = rdy_en_q & ~pkt_full_s & ~(in_sop_q & (pkts_open_q == PKTS_MAX));
   assign pkt_wr_s          = IN_PACKET_TVALID & IN_PACKET_TREADY;
   assign OUT_PACKET_TVALID = (state_q == ST_PASS) & ~pkt_empty_s;
   assign pkt_rd_s          = ~pkt_empty_s &
                              (((state_q == ST_PASS) & OUT_PACKET_TREADY) | (state_q == ST_DROP));
   assign v_pop_s           = (state_q == ST_IDLE) & ~v_empty_s & ~pkt_empty_s;
   assign v_wr_s            = RULE_TVALID & ~v_full_s;

   assign OUT_PACKET_TDATA = head_s[C_BUS_DATA_WIDTH-1:0];
   assign OUT_PACKET_TKEEP = head_s[C_BUS_DATA_WIDTH +: C_BUS_KEEP_WIDTH];
   assign OUT_PACKET_TLAST = head_s[BW-1];
   assign PASS_COUNT       = pass_cnt_q;
   assign DROP_COUNT       = drop_cnt_q;
   assign VERDICT_ERROR    = verr_q;

   // Next-state for FIFO pointers, verdict storage and packet bookkeeping
   always_comb begin
      pkt_wr_d    = pkt_wr_q;
      pkt_rd_d    = pkt_rd_q;
      v_mem_d     = v_mem_q;
      v_wr_d      = v_wr_q;
      v_rd_d      = v_rd_q;
      in_sop_d    = in_sop_q;
      pkts_open_d = pkts_open_q;
      verr_d      = verr_q;

      if (pkt_wr_s) begin
         pkt_wr_d = pkt_wr_q + (FAW + 1)'(1);
         in_sop_d = IN_PACKET_TLAST;
      end else begin
         pkt_wr_d = pkt_wr_q;
         in_sop_d = in_sop_q;
      end

      if (pkt_rd_s) begin
         pkt_rd_d = pkt_rd_q + (FAW + 1)'(1);
      end else begin
         pkt_rd_d = pkt_rd_q;
      end

      case ({pkt_wr_s & in_sop_q, v_pop_s})
         2'b10:   pkts_open_d = pkts_open_q + (VAW + 1)'(1);
         2'b01:   pkts_open_d = pkts_open_q - (VAW + 1)'(1);
         default: pkts_open_d = pkts_open_q;
      endcase

      if (v_wr_s) begin
         v_mem_d[v_wr_q[VAW-1:0]] = RULE_TDATA ~^ C_PASS_ON_MATCH;
         v_wr_d                   = v_wr_q + (VAW + 1)'(1);
      end else begin
         v_wr_d = v_wr_q;
      end

      if (v_pop_s) begin
         v_rd_d = v_rd_q + (VAW + 1)'(1);
      end else begin
         v_rd_d = v_rd_q;
      end

      if (RULE_TVALID && v_full_s) begin
         verr_d = 1'b1;
      end else begin
         verr_d = verr_q;
      end
   end

   // Control registers; reset empties both FIFOs by clearing their pointers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pkt_wr_q    <= '0;
         pkt_rd_q    <= '0;
         v_mem_q     <= '0;
         v_wr_q      <= '0;
         v_rd_q      <= '0;
         in_sop_q    <= 1'b1;
         pkts_open_q <= '0;
         verr_q      <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         pkt_wr_q    <= pkt_wr_d;
         pkt_rd_q    <= pkt_rd_d;
         v_mem_q     <= v_mem_d;
         v_wr_q      <= v_wr_d;
         v_rd_q      <= v_rd_d;
         in_sop_q    <= in_sop_d;
         pkts_open_q <= pkts_open_d;
         verr_q      <= verr_d;
         rdy_en_q    <= 1'b1;
      end
   end

   // Packet beat storage
   always_ff @(posedge CLK) begin
      if (pkt_wr_s) begin
         pkt_mem_q[pkt_wr_q[FAW-1:0]] <= {IN_PACKET_TLAST, IN_PACKET_TKEEP, IN_PACKET_TDATA};
      end
   end

   // Egress FSM with pass/drop statistics
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         pass_cnt_q <= 32'd0;
         drop_cnt_q <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (v_pop_s) begin
                  if (v_head_s) begin
                     state_q    <= ST_PASS;
                     pass_cnt_q <= pass_cnt_q + 32'd1;
                  end else begin
                     state_q    <= ST_DROP;
                     drop_cnt_q <= drop_cnt_q + 32'd1;
                  end
               end
            end
            ST_PASS, ST_DROP: begin
               if (pkt_rd_s && head_s[BW-1]) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
